// File: rtl/board_io_pkg.sv
// Shared constants and width helpers for the board I/O conditioning slice.
package board_io_pkg;

  // 5 ms of stable level at a 100 MHz system clock.
  localparam int DB_CYCLES_100MHZ    = 500000;
  localparam int RST_HOLD_DEFAULT    = 16;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Bits needed to count from 0 up to and including max_val (never below 1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One conditioned input: synchroniser chain, debouncer and registered edge pulses.
module debounce_ch
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,  // legal range 2..4
  parameter int DB_CYCLES   = DB_CYCLES_100MHZ      // minimum 1
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW      = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [CW-1:0]          cnt_p1;
  logic                   synced;

  assign synced = sync_p0[SYNC_STAGES-1];

  // Synchroniser: a plain shift chain, nothing between the stages.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d_i};
    end
  end

  // Debouncer: a new level is taken only after DB_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count, and the
  // count is cleared on acceptance so it can never wrap.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_p1 <= '0;
      q_o    <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (synced == q_o) begin
        cnt_p1 <= '0;
      end else if (cnt_p1 == DB_LAST) begin
        cnt_p1 <= '0;
        q_o    <= synced;
        rise_o <= synced;
        fall_o <= ~synced;
      end else begin
        cnt_p1 <= cnt_p1 + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/board_io_cond.sv
// Board-side I/O conditioning: SoC reset sequencer plus debounced buttons
// and switches with IRQ-ready edge pulses.
module board_io_cond
  import board_io_pkg::*;
#(
  parameter int N_BTN           = 1,
  parameter int N_SW            = 16,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DB_CYCLES       = DB_CYCLES_100MHZ,
  parameter int RST_HOLD_CYCLES = RST_HOLD_DEFAULT
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [N_BTN-1:0] btn_i,
  input  logic [N_SW-1:0]  sw_i,
  output logic             srst_o,
  output logic [N_BTN-1:0] btn_o,
  output logic [N_BTN-1:0] btn_rise_o,
  output logic [N_BTN-1:0] btn_fall_o,
  output logic [N_SW-1:0]  sw_o,
  output logic             sw_chg_o
);

  localparam int            HW       = cnt_width(RST_HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(RST_HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic [HW-1:0]    hold_cnt;
  logic [N_BTN-1:0] btn_rise_raw;
  logic [N_BTN-1:0] btn_fall_raw;
  logic [N_SW-1:0]  sw_rise_raw;
  logic [N_SW-1:0]  sw_fall_raw;

  // Reset sequencer: srst_o asserts with arst_i and is released on the edge
  // where the hold counter reaches RST_HOLD_CYCLES; the counter then parks.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      hold_cnt <= '0;
      srst_o   <= 1'b1;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + HOLD_ONE;
      if (hold_cnt == HOLD_LAST) begin
        srst_o <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_btn (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .d_i    (btn_i[i]),
      .q_o    (btn_o[i]),
      .rise_o (btn_rise_raw[i]),
      .fall_o (btn_fall_raw[i])
    );
  end

  for (genvar j = 0; j < N_SW; j++) begin : g_sw
    debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_sw (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .d_i    (sw_i[j]),
      .q_o    (sw_o[j]),
      .rise_o (sw_rise_raw[j]),
      .fall_o (sw_fall_raw[j])
    );
  end

  // Pulses are dropped while the SoC is held in reset, so levels that settle
  // during the hold appear at release without a spurious edge. All pulse
  // sources are flop outputs, so the gated result stays glitch-free.
  assign btn_rise_o = btn_rise_raw & {N_BTN{~srst_o}};
  assign btn_fall_o = btn_fall_raw & {N_BTN{~srst_o}};
  assign sw_chg_o   = (|(sw_rise_raw | sw_fall_raw)) & ~srst_o;

endmodule
